// File: rtl/sseg_capture_if.sv
// Seven-segment capture bus: scanned anode/cathode lines in, decoded digits and status pulses out.
interface sseg_capture_if;
  logic [3:0] sseg_an;
  logic [6:0] sseg_ca;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit_valid;
  logic       frame_strobe;
  logic       decode_err;
  logic       multi_an_err;

  modport master (
    output sseg_an, sseg_ca,
    input  digit0, digit1, digit2, digit3, digit_valid, frame_strobe, decode_err, multi_an_err
  );

  modport slave (
    input  sseg_an, sseg_ca,
    output digit0, digit1, digit2, digit3, digit_valid, frame_strobe, decode_err, multi_an_err
  );
endinterface

// File: rtl/sseg_capture.sv
// Recovers hex digits from a multiplexed seven-segment display by waiting for each
// anode/cathode pattern to settle, then decoding it once per stable dwell.
module sseg_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  sseg_capture_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_MAX   = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLING, HELD} state_t;
  state_t state, state_nx;

  logic [3:0]    an_p0, an_p1;
  logic [6:0]    ca_p0, ca_p1;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          changed, eval;
  logic [4:0]    dec;
  logic [1:0]    sel;
  logic          single;
  logic [3:0]    cap, clr, seen, seen_base;
  logic          derr_nx, merr_nx;
  logic [3:0]    digit_q [4];
  logic [3:0]    valid_q;
  logic          strobe_q, derr_q, merr_q;

  // Returns {hit, value}; hit is 0 for blank and for unknown patterns.
  function automatic logic [4:0] seg_decode(input logic [6:0] ca);
    case (ca)
      7'b1000000: return 5'h10;
      7'b1111001: return 5'h11;
      7'b0100100: return 5'h12;
      7'b0110000: return 5'h13;
      7'b0011001: return 5'h14;
      7'b0010010: return 5'h15;
      7'b0000010: return 5'h16;
      7'b1111000: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0010000: return 5'h19;
      7'b0001000: return 5'h1A;
      7'b0000011: return 5'h1B;
      7'b1000110: return 5'h1C;
      7'b0100001: return 5'h1D;
      7'b0000110: return 5'h1E;
      7'b0001110: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= SETTLE_MAX) ? SETTLE_MAX : v + 1'b1;
  endfunction

  // Stage p0: input sample; stage p1: previous sample for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_p0 <= 4'hF;
      ca_p0 <= 7'h7F;
      an_p1 <= 4'hF;
      ca_p1 <= 7'h7F;
      cnt   <= '0;
    end else begin
      an_p0 <= bus.sseg_an;
      ca_p0 <= bus.sseg_ca;
      an_p1 <= an_p0;
      ca_p1 <= ca_p0;
      cnt   <= changed ? CW'(1) : sat_inc(cnt);
    end
  end

  assign changed = {an_p0, ca_p0} != {an_p1, ca_p1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    eval     = 1'b0;
    if (an_p0 == 4'hF) begin
      state_nx = IDLE;
    end else if (changed) begin
      state_nx = SETTLING;
    end else if (state == SETTLING && sat_inc(cnt) == SETTLE_MAX) begin
      state_nx = HELD;
      eval     = 1'b1;
    end
  end

  always_comb begin
    dec     = seg_decode(ca_p0);
    sel     = 2'd0;
    single  = 1'b0;
    cap     = '0;
    clr     = '0;
    derr_nx = 1'b0;
    merr_nx = 1'b0;
    case (an_p0)
      4'b1110: begin sel = 2'd0; single = 1'b1; end
      4'b1101: begin sel = 2'd1; single = 1'b1; end
      4'b1011: begin sel = 2'd2; single = 1'b1; end
      4'b0111: begin sel = 2'd3; single = 1'b1; end
      default: ;
    endcase
    if (eval) begin
      if (!single) begin
        merr_nx = 1'b1;
      end else if (dec[4]) begin
        cap[sel] = 1'b1;
      end else begin
        clr[sel] = 1'b1;
        derr_nx  = (ca_p0 != 7'h7F);
      end
    end
  end

  assign seen_base = (seen == 4'hF) ? 4'h0 : seen;

  // Stage p2: registered outputs; a capture always beats the timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= '0;
      valid_q  <= '0;
      seen     <= '0;
      tcnt     <= '0;
      strobe_q <= 1'b0;
      derr_q   <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      strobe_q <= (seen == 4'hF);
      derr_q   <= derr_nx;
      merr_q   <= merr_nx;
      if (cap != '0) begin
        digit_q[sel] <= dec[3:0];
        valid_q      <= (valid_q & ~clr) | cap;
        seen         <= seen_base | cap;
        tcnt         <= '0;
      end else if (tcnt == TIMEOUT_LAST) begin
        valid_q <= '0;
        seen    <= '0;
        tcnt    <= '0;
      end else begin
        valid_q <= valid_q & ~clr;
        seen    <= seen_base;
        tcnt    <= tcnt + 1'b1;
      end
    end
  end

  assign bus.digit0       = digit_q[0];
  assign bus.digit1       = digit_q[1];
  assign bus.digit2       = digit_q[2];
  assign bus.digit3       = digit_q[3];
  assign bus.digit_valid  = valid_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.decode_err   = derr_q;
  assign bus.multi_an_err = merr_q;
endmodule

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4 (min 2): consecutive identical samples of (sseg_an, sseg_ca) required before a digit is captured.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: cycles without any successful capture before all digit_valid bits clear.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sseg_an  input  4  anode enables, active-low; bit n selects digit n.
REQ-006 sseg_ca  input  7  segment cathodes, active-low, {g,f,e,d,c,b,a} = bits [6:0].
REQ-007 digit0, digit1, digit2, digit3  output  4 each  last captured hex value per digit position.
REQ-008 digit_valid  output  4  bit n high when digitn holds a value decoded since the last clear.
REQ-009 frame_strobe  output  1  one-cycle pulse when all four positions have captured since the previous strobe.
REQ-010 decode_err  output  1  one-cycle pulse: stable single-anode pattern not in decode table and not blank.
REQ-011 multi_an_err  output  1  one-cycle pulse: stable pattern with more than one anode low.

Function
REQ-012 Inputs SHALL be registered once; all decisions use the registered pair; all outputs registered.
REQ-013 A stability counter SHALL reset to 1 when the sampled pair differs from the previous sample and increment (saturating at SETTLE_CYCLES) otherwise.
REQ-014 FSM states SHALL be IDLE, SETTLING, HELD; any sampled-pair change -> SETTLING; counter reaching SETTLE_CYCLES -> evaluate once -> HELD; HELD persists until the pair changes.
REQ-015 Evaluation SHALL occur exactly once per stable dwell, on the edge at which the counter reaches SETTLE_CYCLES; outputs change on that edge.
REQ-016 Decode table (ca, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 Single anode n low, pattern in table: digitn <= value, digit_valid[n] <= 1, seen[n] <= 1, timeout counter <= 0.
REQ-018 Single anode n low, ca = 1111111 (blank): digit_valid[n] <= 0, digitn unchanged, no error, seen unchanged.
REQ-019 Single anode n low, pattern neither in table nor blank: decode_err pulse, digit_valid[n] <= 0, digitn unchanged.
REQ-020 Two or more anodes low: multi_an_err pulse, no digit/valid/seen change.
REQ-021 All anodes high (1111): FSM -> IDLE, no evaluation, no error.
REQ-022 When seen becomes 1111 (including the capture completing it), frame_strobe SHALL pulse on the following edge and seen SHALL clear to 0000; a capture on the strobe edge is recorded in the new seen.
REQ-023 Timeout counter SHALL increment every cycle without a successful capture; on reaching TIMEOUT_CYCLES, digit_valid <= 0000 and seen <= 0000, counter restarts at 0.
REQ-024 Capture and timeout on the same edge: capture wins, counter cleared.
REQ-025 Repeated capture of the same anode SHALL overwrite digitn and does not pulse frame_strobe by itself.

Reset
REQ-026 On rst_n low, asynchronously: digit0..3 = 0, digit_valid = 0000, frame_strobe = decode_err = multi_an_err = 0, seen = 0000, counters = 0, FSM = IDLE, input register = {1111, 1111111}.
REQ-027 Reset asserted mid-dwell SHALL discard the in-progress evaluation; after release, a dwell needs a full SETTLE_CYCLES of samples.

Verification
REQ-028 Scan an=1110/1101/1011/0111 with ca 0/1/2/3 patterns, 8 cycles each -> digit0..3 = 0,1,2,3, digit_valid=1111, one frame_strobe per full scan.
REQ-029 an=1110, ca=0100100 held exactly 3 cycles then changed (SETTLE_CYCLES=4) -> no capture, digit0 unchanged, no pulses.
REQ-030 an=0110 with ca=0000000, held 6 cycles -> single multi_an_err pulse, outputs unchanged.
REQ-031 an=1011, ca=1111110 held 6 cycles -> single decode_err pulse, digit_valid[2]=0; then ca=1111111 -> no error.
REQ-032 After full capture, an=1111 for TIMEOUT_CYCLES (overridden to 50) -> digit_valid=0000 at cycle 50, digits retained.
REQ-033 rst_n pulsed low for 1 cycle during a dwell at counter=3 -> all outputs zero immediately, capture requires 4 further stable samples.
